// File: rtl/in_port_scheduler.sv
// Round-robin scheduler sharing one synchronous-read input memory among N_PORTS input ports.
// Define IN_PORT_SCHED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module in_port_scheduler #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned BURST   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_PORTS-1:0]         port_mask,
    input  logic [N_PORTS*ADDR_W-1:0]  port_base,
    input  logic [N_PORTS*CNT_W-1:0]   port_size,
    input  logic [N_PORTS-1:0]         rdy,
    output logic                       mem_en,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [N_PORTS-1:0]         send,
    output logic [$clog2(N_PORTS)-1:0] sel,
    output logic                       free,
    output logic                       busy,
    output logic                       done
);
    localparam int unsigned       SEL_W    = $clog2(N_PORTS);
    localparam logic [CNT_W-1:0]  BURST_C  = CNT_W'(BURST);
    localparam logic [SEL_W-1:0]  LAST_RST = SEL_W'(N_PORTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_FREE, S_DONE} state_t;
    state_t state, state_nx;

    logic [N_PORTS-1:0] mask_q;
    logic [CNT_W-1:0]   cnt [N_PORTS];
    logic [CNT_W-1:0]   bcnt;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic [N_PORTS-1:0] send_q;

    logic [ADDR_W-1:0]  base_a [N_PORTS];
    logic [CNT_W-1:0]   size_a [N_PORTS];
    logic [N_PORTS-1:0] pending;
    logic [N_PORTS-1:0] sel_oh;
    logic               any_pending;
    logic               hit;
    logic [SEL_W-1:0]   grant_idx;
    logic [ADDR_W-1:0]  base_sel;
    logic [CNT_W-1:0]   cnt_sel, size_sel, cnt_inc, bcnt_inc;
    logic               read_ok, burst_end;

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            base_a[i]  = port_base[i*ADDR_W +: ADDR_W];
            size_a[i]  = port_size[i*CNT_W +: CNT_W];
            pending[i] = mask_q[i] && (cnt[i] < size_a[i]);
        end
    end

    always_comb begin
        any_pending = |pending;
    end

    always_comb begin
`ifndef IN_PORT_SCHED_PRIO_EN
        int unsigned      idx;
        logic [SEL_W-1:0] cand;
        idx  = 0;
        cand = '0;
`endif
        hit       = 1'b0;
        grant_idx = '0;
`ifdef IN_PORT_SCHED_PRIO_EN
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!hit && pending[SEL_W'(i)] && rdy[SEL_W'(i)]) begin
                hit       = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
`else
        // Walk last+1 .. last+N_PORTS modulo N_PORTS; first pending ready port wins.
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= N_PORTS)
                idx = idx - N_PORTS;
            cand = SEL_W'(idx);
            if (!hit && pending[cand] && rdy[cand]) begin
                hit       = 1'b1;
                grant_idx = cand;
            end
        end
`endif
    end

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
        base_sel      = base_a[sel_q];
        cnt_sel       = cnt[sel_q];
        size_sel      = size_a[sel_q];
        cnt_inc       = cnt_sel + 1'b1;
        bcnt_inc      = bcnt + 1'b1;
        read_ok       = (state == S_READ) && rdy[sel_q] && (bcnt < BURST_C) && (cnt_sel < size_sel);
        // Exit on post-increment values so the last permitted word goes straight to FREE.
        burst_end     = (bcnt_inc == BURST_C) || (cnt_inc == size_sel);
    end

    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        mem_addr = '0;
        free     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_ARB;
            end
            S_ARB: begin
                busy = 1'b1;
                if (!any_pending)
                    state_nx = S_DONE;
                else if (hit)
                    state_nx = S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                if (read_ok) begin
                    mem_en   = 1'b1;
                    mem_addr = base_sel + ADDR_W'(cnt_sel);
                    state_nx = burst_end ? S_FREE : S_READ;
                end else begin
                    state_nx = S_FREE;
                end
            end
            S_FREE: begin
                busy     = 1'b1;
                free     = 1'b1;
                state_nx = S_ARB;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mask_q <= '0;
            bcnt   <= '0;
            sel_q  <= '0;
            last_q <= LAST_RST;
            send_q <= '0;
            for (int unsigned i = 0; i < N_PORTS; i++)
                cnt[i] <= '0;
        end else begin
            state  <= state_nx;
            // Memory data arrives one cycle after the read enable.
            send_q <= read_ok ? sel_oh : '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= port_mask;
                        for (int unsigned i = 0; i < N_PORTS; i++)
                            cnt[i] <= '0;
                    end
                end
                S_ARB: begin
                    if (any_pending && hit) begin
                        sel_q <= grant_idx;
                        bcnt  <= '0;
                    end
                end
                S_READ: begin
                    if (read_ok) begin
                        cnt[sel_q] <= cnt_inc;
                        bcnt       <= bcnt_inc;
                    end
                end
                S_FREE: last_q <= sel_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        send = send_q;
        sel  = sel_q;
    end

endmodule

// File: tb/tb_in_port_scheduler.sv
// Directed, table-driven bench for in_port_scheduler: one instance with BURST=8/ADDR_W=10
// and one with BURST=4/ADDR_W=4 (address wrap), plus a hand-written mid-pass reset sequence.
module tb_in_port_scheduler;
`ifdef IN_PORT_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        bit          use_b;
        logic [3:0]  mask;
        logic [39:0] sizes;
        logic [39:0] bases;
        logic [3:0]  drop_mask;
        int          drop_from;
        int          drop_to;
        int          exp_done;
        int          exp_first_rd;
        int          n_grants;
        logic [15:0] g_port;
        logic [31:0] g_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b;
    logic [3:0]  port_mask, rdy;
    logic [39:0] port_size, base_a;
    logic [15:0] base_b;

    logic        a_mem_en, a_free, a_busy, a_done;
    logic [9:0]  a_mem_addr;
    logic [3:0]  a_send;
    logic [1:0]  a_sel;
    logic        b_mem_en, b_free, b_busy, b_done;
    logic [3:0]  b_mem_addr;
    logic [3:0]  b_send;
    logic [1:0]  b_sel;

    int n_checks;
    int n_bad;
    vec_t tbl[8];
    vec_t post;

    in_port_scheduler #(.N_PORTS(4), .ADDR_W(10), .CNT_W(10), .BURST(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .port_mask(port_mask), .port_base(base_a),
        .port_size(port_size), .rdy(rdy), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
        .send(a_send), .sel(a_sel), .free(a_free), .busy(a_busy), .done(a_done)
    );

    in_port_scheduler #(.N_PORTS(4), .ADDR_W(4), .CNT_W(10), .BURST(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .port_mask(port_mask), .port_base(base_b),
        .port_size(port_size), .rdy(rdy), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
        .send(b_send), .sel(b_sel), .free(b_free), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_a_quiet(input string tag);
        check({tag, " mem_en"},   int'(a_mem_en),   0);
        check({tag, " mem_addr"}, int'(a_mem_addr), 0);
        check({tag, " send"},     int'(a_send),     0);
        check({tag, " sel"},      int'(a_sel),      0);
        check({tag, " free"},     int'(a_free),     0);
        check({tag, " busy"},     int'(a_busy),     0);
        check({tag, " done"},     int'(a_done),     0);
    endtask

    function automatic logic [39:0] p10(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [15:0] p4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [31:0] p8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t mk(input bit use_b, input logic [3:0] mask, input logic [39:0] sizes,
                                input logic [39:0] bases, input int n, input logic [15:0] gp,
                                input logic [31:0] gl, input int exp_done, input int first_rd);
        vec_t v;
        v.use_b = use_b;  v.mask = mask;  v.sizes = sizes;  v.bases = bases;
        v.drop_mask = 4'h0;  v.drop_from = 0;  v.drop_to = 0;
        v.n_grants = n;  v.g_port = gp;  v.g_len = gl;
        v.exp_done = exp_done;  v.exp_first_rd = first_rd;
        return v;
    endfunction

    // Runs one pass; grant order, burst lengths and per-port addresses come from the record.
    task automatic run_vec(input vec_t v, input string tag);
        int gi, cur_len, p, done_c, first_rd, first_snd, addr, sl, amask, exp_first_snd;
        int widx[4];
        int sends[4];
        int exp_snd[4];
        logic men, fr, dn, bs;
        logic [3:0] snd;
        amask = v.use_b ? 'hF : 'h3FF;
        gi = 0;  cur_len = 0;  done_c = -1;  first_rd = -1;  first_snd = -1;
        for (int i = 0; i < 4; i++) begin
            widx[i] = 0;  sends[i] = 0;  exp_snd[i] = 0;
            base_b[i*4 +: 4] = v.bases[i*10 +: 4];
        end
        port_mask = v.mask;
        port_size = v.sizes;
        base_a    = v.bases;
        @(posedge clk); #1;
        rdy = 4'hF;
        if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
        for (int cyc = 1; cyc < 300 && done_c < 0; cyc++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            rdy = (v.drop_mask != 0 && cyc >= v.drop_from && cyc <= v.drop_to) ? ~v.drop_mask : 4'hF;
            @(negedge clk);
            men  = v.use_b ? b_mem_en : a_mem_en;
            fr   = v.use_b ? b_free   : a_free;
            dn   = v.use_b ? b_done   : a_done;
            bs   = v.use_b ? b_busy   : a_busy;
            snd  = v.use_b ? b_send   : a_send;
            addr = v.use_b ? int'(b_mem_addr) : int'(a_mem_addr);
            sl   = v.use_b ? int'(b_sel) : int'(a_sel);
            p    = (gi < v.n_grants) ? int'(v.g_port[gi*4 +: 4]) : 0;
            if (cyc == 1)
                check({tag, " busy after start"}, int'(bs), 1);
            if (snd != 4'h0) begin
                if (first_snd < 0) first_snd = cyc;
                check({tag, " send onehot"}, $countones(snd), 1);
                for (int i = 0; i < 4; i++)
                    if (snd[i]) sends[i]++;
            end
            if (men) begin
                if (first_rd < 0) first_rd = cyc;
                check($sformatf("%s addr grant%0d word%0d", tag, gi, cur_len), addr,
                      (int'(v.bases[p*10 +: 10]) + widx[p]) & amask);
                widx[p]++;
                cur_len++;
            end
            if (fr) begin
                check($sformatf("%s sel grant%0d", tag, gi), sl, p);
                check($sformatf("%s burst len grant%0d", tag, gi), cur_len,
                      (gi < v.n_grants) ? int'(v.g_len[gi*8 +: 8]) : 0);
                gi++;
                cur_len = 0;
            end
            if (dn) begin
                done_c = cyc;
                check({tag, " busy at done"}, int'(bs), 0);
            end
        end
        check({tag, " done cycle"}, done_c, v.exp_done);
        check({tag, " grant count"}, gi, v.n_grants);
        for (int g = 0; g < v.n_grants; g++)
            exp_snd[v.g_port[g*4 +: 4]] += int'(v.g_len[g*8 +: 8]);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s send count port%0d", tag, i), sends[i], exp_snd[i]);
        exp_first_snd = (v.exp_first_rd < 0) ? -1 : v.exp_first_rd + 1;
        check({tag, " first read cycle"}, first_rd, v.exp_first_rd);
        check({tag, " first send cycle"}, first_snd, exp_first_snd);
        @(negedge clk);
        check({tag, " done one pulse"}, v.use_b ? int'(b_done) : int'(a_done), 0);
        check({tag, " idle after done"}, v.use_b ? int'(b_busy) : int'(a_busy), 0);
    endtask

    initial begin
        n_checks = 0;  n_bad = 0;
        rst = 1'b1;  start_a = 1'b0;  start_b = 1'b0;
        port_mask = '0;  rdy = 4'hF;  port_size = '0;  base_a = '0;  base_b = '0;

        // A: BURST=8 ADDR_W=10; B: BURST=4 ADDR_W=4. Round-robin pointer persists across passes.
        tbl[0] = mk(1'b0, 4'b0001, p10(5, 0, 0, 0), p10('h100, 0, 0, 0),
                    1, p4(0, 0, 0, 0), p8(5, 0, 0, 0), 9, 2);
        tbl[1] = mk(1'b1, 4'b0011, p10(10, 3, 0, 0), p10('h0, 'h8, 0, 0), 4,
                    PRIO ? p4(0, 0, 0, 1) : p4(0, 1, 0, 0),
                    PRIO ? p8(4, 4, 2, 3) : p8(4, 3, 4, 2), 23, 2);
        tbl[2] = mk(1'b0, 4'b1011, p10(3, 0, 5, 2), p10('h200, 'h300, 'h3F0, 'h3FF), 2,
                    PRIO ? p4(0, 3, 0, 0) : p4(3, 0, 0, 0),
                    PRIO ? p8(3, 2, 0, 0) : p8(2, 3, 0, 0), 11, 2);
        tbl[3] = mk(1'b0, 4'b0000, p10(3, 3, 3, 3), p10(0, 0, 0, 0),
                    0, p4(0, 0, 0, 0), p8(0, 0, 0, 0), 2, -1);
        tbl[4] = mk(1'b1, 4'b0100, p10(0, 0, 4, 0), p10(0, 0, 'hE, 0),
                    1, p4(2, 0, 0, 0), p8(4, 0, 0, 0), 8, 2);
        tbl[5] = mk(1'b0, 4'b0111, p10(9, 2, 8, 0), p10('h000, 'h020, 'h040, 0), 4,
                    PRIO ? p4(0, 0, 1, 2) : p4(1, 2, 0, 0),
                    PRIO ? p8(8, 1, 2, 8) : p8(2, 8, 8, 1), 29, 2);
        tbl[6] = mk(1'b1, 4'b0001, p10(6, 0, 0, 0), p10(0, 0, 0, 0),
                    2, p4(0, 0, 0, 0), p8(2, 4, 0, 0), 16, 2);
        tbl[6].drop_mask = 4'b0001;
        tbl[6].drop_from = 4;
        tbl[6].drop_to   = 8;
        tbl[7] = mk(1'b1, 4'b0011, p10(8, 8, 0, 0), p10(0, 8, 0, 0), 4,
                    PRIO ? p4(0, 0, 1, 1) : p4(1, 0, 1, 0), p8(4, 4, 4, 4), 26, 2);
        post   = mk(1'b0, 4'b0011, p10(2, 2, 0, 0), p10('h10, 'h40, 0, 0),
                    2, p4(0, 1, 0, 0), p8(2, 2, 0, 0), 10, 2);

        #12;
        check_a_quiet("reset");
        check("reset b busy", int'(b_busy), 0);
        check("reset b send", int'(b_send), 0);
        check("reset b mem_en", int'(b_mem_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 8; t++)
            run_vec(tbl[t], $sformatf("v%0d", t));

        // Reset in the middle of a READ burst on A, one send in flight.
        port_mask = 4'b0011;
        port_size = p10(20, 20, 0, 0);
        base_a    = p10('h10, 'h40, 0, 0);
        rdy       = 4'hF;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("midrst arb busy", int'(a_busy), 1);
        @(posedge clk); #1;
        check("midrst pre sel", int'(a_sel), PRIO ? 0 : 1);
        check("midrst pre addr", int'(a_mem_addr), PRIO ? 'h10 : 'h40);
        @(posedge clk); #1;
        check("midrst pre send", int'(a_send), PRIO ? 1 : 2);
        rst = 1'b1;
        #1;
        check_a_quiet("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst no done", int'(a_done), 0);
            check("midrst stays idle", int'(a_busy), 0);
        end
        run_vec(post, "postrst");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/in_port_scheduler.md
# in_port_scheduler

Round-robin scheduler that shares one synchronous-read input memory among `N_PORTS` dataflow input ports. For each port it generates memory read enables, addresses and per-port `send` strobes in bursts of at most `BURST` words, until every enabled port has received its programmed word count. It sits between the input memory and the generic-port network of the multi-dataflow coprocessor. It replaces per-port loading FSMs chained by a select/free token.

## Interface
- `N_PORTS`, 4, number of input ports (2..8)
- `ADDR_W`, 10, memory address width
- `CNT_W`, 10, per-port word-count width
- `BURST`, 8, maximum words per grant (1..2^CNT_W-1)

Reset is `rst`, asynchronous, active-high; the clock is `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  single-cycle pulse; begins a loading pass
- `port_mask`  in  N_PORTS  ports taking part in the pass; latched on `start`
- `port_base`  in  N_PORTS*ADDR_W  base address per port; port i is bits [i*ADDR_W +: ADDR_W]; must be stable while `busy`
- `port_size`  in  N_PORTS*CNT_W  words to load per port; must be stable while `busy`
- `rdy`  in  N_PORTS  downstream port i can accept one more word
- `mem_en`  out  1  memory read enable
- `mem_addr`  out  ADDR_W  memory read address
- `send`  out  N_PORTS  one-hot data-valid to port i; memory data is valid in this cycle
- `sel`  out  log2(N_PORTS)  index of the granted port
- `free`  out  1  one-cycle pulse when a grant is released
- `busy`  out  1  a pass is in progress
- `done`  out  1  one-cycle pulse when the pass completes

## Operation
- The scheduler is a state machine with states IDLE, ARB, READ, FREE and DONE.
- **IDLE:** `start` latches `port_mask`, clears all per-port counters `cnt[i]`, and moves to ARB. `start` is ignored in every other state.
- **ARB:** a port is *pending* when its mask bit is 1 and `cnt[i] < port_size[i]`; a port with size 0 is never pending.
  - No port pending: go to DONE.
  - Otherwise, search from `last+1` (mod N_PORTS) for the first pending port with `rdy=1`. On a hit, register `sel`, clear the burst counter and go to READ.
  - Pending ports exist but none has `rdy=1`: stay in ARB.
- **READ:** in each cycle where `rdy[sel]=1`, `bcnt<BURST` and `cnt[sel]<port_size[sel]`:
  - assert `mem_en=1` with `mem_addr = port_base[sel] + cnt[sel]`, truncated to ADDR_W (wraps);
  - increment `cnt[sel]` and `bcnt`.
  - If any of these conditions is false, no read is issued and the state moves to FREE.
  - The exit test uses post-increment values: when the last permitted word of a burst or of the port is issued, the next state is FREE.
- **FREE:** one cycle. `free=1`, `last<=sel`, then go to ARB.
- **DONE:** one cycle. `done=1`, then go to IDLE.
- **`send`:** `send[i]` is `mem_en & (sel==i)` delayed by one register, matching the memory's one-cycle read latency. `send` is therefore still asserted in the first FREE cycle after the final read.
- **`rdy` semantics:** `rdy` sampled high means the port can absorb the word arriving one cycle later. Ports therefore deassert `rdy` one word early.
- **Reset values:** all outputs are 0, the state is IDLE, `last = N_PORTS-1` (so the first search starts at port 0), and all counters are 0.
- **`busy`:** 1 in ARB, READ and FREE.
- **Reset mid-pass:** the pass is aborted. No `done` is produced, and any in-flight `send` is dropped.

## Timing
- `start` in cycle 0: ARB in cycle 1, READ in cycle 2 with the first `mem_en`, first `send` in cycle 3.
- A full burst of B words uses READ cycles 2..B+1, sends in cycles 3..B+2, and FREE in cycle B+2.
- Re-arbitration costs 2 idle memory cycles (FREE, ARB) between bursts.
- `done` is asserted in the cycle after the ARB that finds no pending port.
- Simultaneous `rdy` drop and last word: the last word is issued if `rdy` was high in that cycle. FREE follows either way.

## Configuration
- `IN_PORT_SCHED_PRIO_EN` defined: ARB uses fixed priority. The lowest-index pending ready port wins, and `last` is unused.
- Undefined (default): round-robin from `last+1` as described above.

## Test plan
- **Single port:** N=4, mask=0001, size0=5, base0=0x100, BURST=8, `rdy` always 1.
  - `mem_addr` 0x100..0x104 in cycles 2-6; `send[0]` in cycles 3-7.
  - One `free` pulse; `done` in cycle 9.
- **Round-robin interleave:** mask=0011, sizes 10/3, BURST=4.
  - Grant order 0,1,0,0 with bursts of 4,3,4,2 words.
  - `send` counts per port are 10 and 3.
- **Backpressure:** `rdy[0]` drops after the 2nd read of a 4-word burst.
  - The burst ends after 2 words, then `free`.
  - ARB stalls until `rdy[0]` returns; the remaining words follow with no loss or duplication.
- **Zero-size and masked ports:** mask=1011, size1=0.
  - Ports 1 and 2 never get `send`; `done` still fires.
  - Mask=0000: `done` in cycle 2.
- **Address wrap:** ADDR_W=4, base=0xE, size=4 gives addresses E, F, 0, 1.
- **Reset and priority:**
  - `rst` mid-READ: all outputs 0 next cycle, and a fresh `start` restarts from port 0.
  - With `IN_PORT_SCHED_PRIO_EN`, mask=0011 and sizes 8/8, BURST=4: order is 0,0,1,1.
